c157x_rom_fetch: RTL and testbench
==================================

// Module: c157x_rom_fetch
// PURPOSE
//  Serves the drive-ROM fetches for all drives of the c157x multi-drive block from one single-port ROM store.
//  Each 2 MHz slot it latches every drive's 15-bit ROM address and drive mode, then issues one request per drive to the memory port.
//  Returns byte data to the drives (rom_do[]).
//  Tracks ROM-image loads to derive the per-drive empty8k flag (8K ROM with free 8K window for parallel/ext RAM).
//  Sits directly upstream of c157x_multi; drives the mem_a/rom_do/empty8k ports.
// PARAMETERS
//  NDR    2  number of drives served, legal 1..4
//  CACHE  1  1 = skip fetch when drive address+mode unchanged since last completed fetch
// PORTS
//  clk         in   1      16 MHz drive clock (same as c157x_multi clk)
//  reset_n     in   1      asynchronous, active-low reset
//  slot_start  in   1      1-clk strobe at start of each 2 MHz slot (ph2_f[1])
//  drv_mode    in   2xNDR  ROM image per drive: 0=1541 1=1570 2=1571 3=1571CR
//  mem_a       in   15xNDR ROM byte address requested by each drive
//  rom_do      out  8xNDR  fetched ROM byte per drive, held until next fetch
//  mem_req     out  1      memory request, held until mem_ack
//  mem_addr    out  17     {image[1:0], addr[14:0]}, stable while mem_req=1
//  mem_ack     in   1      1-clk acknowledge; mem_q valid in same cycle
//  mem_q       in   8      memory read data
//  load_wr     in   1      ROM-image load write strobe (clk domain)
//  load_sel    in   2      image being loaded
//  load_addr   in   15     load address
//  load_data   in   8      load data
//  empty8k     out  NDR    per-drive: selected image is 8K with empty low window
//  overrun     out  1      sticky: slot_start arrived before all fetches done
// BEHAVIOUR
//  Reset (async, reset_n=0): rom_do[*]=8'hFF, mem_req=0, mem_addr=0, empty8k=0, overrun=0, all cache-valid bits 0, FSM=IDLE.
//  FSM states:
//   IDLE:  wait for slot_start.
//   LATCH: capture mem_a[]/drv_mode[] into lat_a[]/lat_m[]; idx=0.
//   ISSUE: if CACHE && vld[idx] && {lat_m,lat_a}[idx]==last[idx], skip.
//          Otherwise assert mem_req with mem_addr={lat_m[idx],lat_a[idx]} -> WAIT.
//   WAIT:  on mem_ack, rom_do[idx]<=mem_q, last[idx]<=addr, vld[idx]<=1, deassert mem_req next clk.
//   Advancing: idx==NDR-1 -> IDLE, else idx+1 -> ISSUE.
//  Latency:
//   - slot_start -> LATCH next clk -> mem_req for drive 0 on the following clk.
//   - With 1-clk ack, rom_do[i] updates 3+2*i clks after slot_start; all drives within 8 clks for NDR<=2.
//  Handshake: mem_req/mem_addr must not change until mem_ack; mem_ack while mem_req=0 is ignored.
//  slot_start while not IDLE:
//   - if WAIT, finish the outstanding access (no request dropped on the bus), discard its data;
//   - then go to LATCH with the new addresses; set overrun=1 (cleared only by reset).
//  slot_start same clk as mem_ack: ack completes normally for that idx, then LATCH; overrun set if idx<NDR-1.
//  Mode change on a drive invalidates the cache for that drive through the compare (mode is in last[]).
//  Any load_wr to image m clears vld[i] for every drive with lat_m[i]==m (stale data never returned).
//  empty8k tracking per image img_e8k[4]:
//   - load_wr && load_addr==0 -> img_e8k[load_sel]<=1;
//   - load_wr && load_data!=00 && load_data!=FF && load_addr[14:8]!=0 && load_addr[14:13]==0 -> img_e8k[load_sel]<=0;
//   - both conditions in the same clk: clear wins.
//   - empty8k[i] registered = img_e8k[drv_mode[i]].
//  Widths: idx is 2 bits; mem_addr exactly 17 bits, no wrap beyond 15-bit drive address.
// STRUCTURE
//  Shared package c157x_pkg: typedef drv_img_t (2-bit enum IMG_1541/1570/1571/1571CR),
//  localparam ROM_AW=15, MEM_AW=17, fetch FSM state enum.
//  One sub-module c157x_rom_e8k_track (load snooping, img_e8k[4]); FSM, latches, cache in top.
// TESTING
//  1 NDR=2, 1-clk ack memory, mem_a={15'h0100,15'h7FFF}, modes {0,2}, slot_start:
//    mem_addr 17'h00100 then 17'h17FFF; rom_do updated by clk 5 after strobe; overrun=0.
//  2 CACHE=1, same addresses next slot -> no mem_req at all; rom_do unchanged; change drive1 mode to 3 -> one req 17'h1FFFF.
//  3 Memory ack delayed 12 clks, slot_start during WAIT:
//    req held stable until ack; overrun=1; new slot re-latches and refetches drive 0 first.
//  4 Load sequence on image 1: write addr 0 -> empty8k for drive on mode 1 goes 1 next clk;
//    write addr 15'h0200 data 8'h55 -> 0; data 8'hFF at 15'h0200 -> stays 1.
//  5 load_wr to image 0 between slots with cached drive on mode 0 -> next slot issues refetch though address unchanged.
//  6 reset_n low during WAIT -> mem_req=0, rom_do=FF, overrun=0 asynchronously; first slot after release fetches all drives.

Source files
------------

// File: rtl/c157x_pkg.sv
// Shared types and constants for the c157x drive-ROM fetch slice.
package c157x_pkg;

    localparam int ROM_AW = 15;
    localparam int MEM_AW = 17;

    typedef enum logic [1:0] {
        IMG_1541   = 2'd0,
        IMG_1570   = 2'd1,
        IMG_1571   = 2'd2,
        IMG_1571CR = 2'd3
    } drv_img_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } fetch_st_t;

    // A real code byte inside the low 8K (outside page 0) proves the window is not empty.
    function automatic logic e8k_clear(input logic [ROM_AW-1:0] addr, input logic [7:0] data);
        return (data != 8'h00) && (data != 8'hFF) &&
               (addr[14:8] != 7'd0) && (addr[14:13] == 2'd0);
    endfunction

endpackage

// File: rtl/c157x_rom_e8k_track.sv
// Snoops ROM-image load writes and keeps one "8K image with empty low window" flag per image.
module c157x_rom_e8k_track
    import c157x_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load_wr,
    input  logic [1:0]        i_load_sel,
    input  logic [ROM_AW-1:0] i_load_addr,
    input  logic [7:0]        i_load_data,
    output logic [3:0]        o_e8k_nxt
);

    logic [3:0] r_img_e8k;
    logic [3:0] w_e8k_nxt;

    // Next flag value; clear has priority over the address-0 set.
    always_comb begin
        w_e8k_nxt = r_img_e8k;
        if (i_load_wr) begin
            if (e8k_clear(i_load_addr, i_load_data)) begin
                w_e8k_nxt[i_load_sel] = 1'b0;
            end else if (i_load_addr == 15'd0) begin
                w_e8k_nxt[i_load_sel] = 1'b1;
            end else begin
                w_e8k_nxt = r_img_e8k;
            end
        end else begin
            w_e8k_nxt = r_img_e8k;
        end
    end

    // Per-image flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_img_e8k <= 4'd0;
        end else begin
            r_img_e8k <= w_e8k_nxt;
        end
    end

    assign o_e8k_nxt = w_e8k_nxt;

endmodule

// File: rtl/c157x_rom_fetch.sv
// Shares one single-port ROM store among NDR drives: per 2 MHz slot, latch every drive's
// address/mode and fetch one byte per drive, skipping drives whose last fetch is still valid.
module c157x_rom_fetch
    import c157x_pkg::*;
#(
    parameter int NDR   = 2,
    parameter int CACHE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  slot_start,
    input  logic [2*NDR-1:0]      drv_mode,
    input  logic [ROM_AW*NDR-1:0] mem_a,
    output logic [8*NDR-1:0]      rom_do,
    output logic                  mem_req,
    output logic [MEM_AW-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_q,
    input  logic                  load_wr,
    input  logic [1:0]            load_sel,
    input  logic [ROM_AW-1:0]     load_addr,
    input  logic [7:0]            load_data,
    output logic [NDR-1:0]        empty8k,
    output logic                  overrun
);

    localparam logic [1:0] LAST_IDX = 2'(NDR - 1);

    fetch_st_t         r_st, w_st_nxt;
    logic [1:0]        r_idx, w_idx_nxt;
    logic [ROM_AW-1:0] r_lat_a  [NDR];
    drv_img_t          r_lat_m  [NDR];
    logic [MEM_AW-1:0] r_last   [NDR];
    logic [7:0]        r_rom_do [NDR];
    logic [NDR-1:0]    r_vld;
    logic              r_mem_req;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_pend;
    logic              r_stale;
    logic              r_overrun;
    logic [NDR-1:0]    r_empty8k;
    logic [3:0]        w_e8k_nxt;
    logic [MEM_AW-1:0] w_cur_addr, w_cur_last;
    logic              w_cur_vld, w_hit, w_is_last, w_ack;
    logic              w_take, w_issue, w_ovr_set;

    c157x_rom_e8k_track u_e8k (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load_wr   (load_wr),
        .i_load_sel  (load_sel),
        .i_load_addr (load_addr),
        .i_load_data (load_data),
        .o_e8k_nxt   (w_e8k_nxt)
    );

    // Select latched request and cache entry of the drive being served.
    always_comb begin
        w_cur_addr = {MEM_AW{1'b0}};
        w_cur_last = {MEM_AW{1'b0}};
        w_cur_vld  = 1'b0;
        for (int i = 0; i < NDR; i++) begin
            w_cur_addr = (r_idx == 2'(i)) ? {r_lat_m[i], r_lat_a[i]} : w_cur_addr;
            w_cur_last = (r_idx == 2'(i)) ? r_last[i] : w_cur_last;
            w_cur_vld  = (r_idx == 2'(i)) ? r_vld[i] : w_cur_vld;
        end
    end

    assign w_hit     = (CACHE != 0) && w_cur_vld && (w_cur_addr == w_cur_last);
    assign w_is_last = (r_idx == LAST_IDX);
    assign w_ack     = mem_ack && r_mem_req;

    // Fetch FSM next state, index and control strobes.
    always_comb begin
        w_st_nxt  = r_st;
        w_idx_nxt = r_idx;
        w_take    = 1'b0;
        w_issue   = 1'b0;
        w_ovr_set = 1'b0;
        case (r_st)
            ST_IDLE: begin
                if (slot_start) begin
                    w_st_nxt = ST_LATCH;
                end else begin
                    w_st_nxt = ST_IDLE;
                end
            end
            ST_LATCH: begin
                w_idx_nxt = 2'd0;
                w_ovr_set = slot_start;
                w_st_nxt  = slot_start ? ST_LATCH : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (slot_start) begin
                    w_ovr_set = 1'b1;
                    w_st_nxt  = ST_LATCH;
                end else if (w_hit) begin
                    w_idx_nxt = w_is_last ? r_idx : r_idx + 2'd1;
                    w_st_nxt  = w_is_last ? ST_IDLE : ST_ISSUE;
                end else begin
                    w_issue  = 1'b1;
                    w_st_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ack) begin
                    // A slot that arrived earlier in this WAIT voids the returning byte.
                    w_take = !r_pend;
                    if (slot_start || r_pend) begin
                        w_ovr_set = slot_start && !w_is_last;
                        w_st_nxt  = ST_LATCH;
                    end else begin
                        w_idx_nxt = w_is_last ? r_idx : r_idx + 2'd1;
                        w_st_nxt  = w_is_last ? ST_IDLE : ST_ISSUE;
                    end
                end else begin
                    w_ovr_set = slot_start;
                    w_st_nxt  = ST_WAIT;
                end
            end
            default: begin
                w_st_nxt  = ST_IDLE;
                w_idx_nxt = 2'd0;
            end
        endcase
    end

    // FSM state and drive index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st  <= ST_IDLE;
            r_idx <= 2'd0;
        end else begin
            r_st  <= w_st_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // Memory handshake, pending-slot, stale-load and overrun flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= {MEM_AW{1'b0}};
            r_pend     <= 1'b0;
            r_stale    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= w_cur_addr;
            end else if (w_ack) begin
                r_mem_req  <= 1'b0;
            end
            if (r_st == ST_LATCH) begin
                r_pend <= 1'b0;
            end else if ((r_st == ST_WAIT) && slot_start && !w_ack) begin
                r_pend <= 1'b1;
            end
            if (w_issue) begin
                r_stale <= 1'b0;
            end else if (load_wr && r_mem_req && (load_sel == r_mem_addr[16:15])) begin
                r_stale <= 1'b1;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Slot latches, returned bytes and per-drive cache tags; load invalidation wins over fill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NDR; i++) begin
                r_lat_a[i]  <= {ROM_AW{1'b0}};
                r_lat_m[i]  <= IMG_1541;
                r_last[i]   <= {MEM_AW{1'b0}};
                r_rom_do[i] <= 8'hFF;
            end
            r_vld <= {NDR{1'b0}};
        end else begin
            for (int i = 0; i < NDR; i++) begin
                if (r_st == ST_LATCH) begin
                    r_lat_a[i] <= mem_a[i*ROM_AW +: ROM_AW];
                    r_lat_m[i] <= drv_img_t'(drv_mode[2*i +: 2]);
                end
                if (w_take && (r_idx == 2'(i))) begin
                    r_rom_do[i] <= mem_q;
                    r_last[i]   <= r_mem_addr;
                    r_vld[i]    <= !r_stale;
                end
                if (load_wr && ((r_lat_m[i] == drv_img_t'(load_sel)) ||
                                (r_last[i][16:15] == load_sel))) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    // Per-drive empty8k follows the image flag selected by the drive's current mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_empty8k <= {NDR{1'b0}};
        end else begin
            for (int i = 0; i < NDR; i++) begin
                r_empty8k[i] <= w_e8k_nxt[drv_mode[2*i +: 2]];
            end
        end
    end

    // Flatten per-drive bytes onto the output bus.
    always_comb begin
        rom_do = {(8*NDR){1'b0}};
        for (int i = 0; i < NDR; i++) begin
            rom_do[8*i +: 8] = r_rom_do[i];
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign empty8k  = r_empty8k;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_c157x_rom_fetch.sv
// Directed bench for c157x_rom_fetch: memory model with programmable ack delay and an
// expected-address scoreboard, plus direct checks on rom_do/empty8k/overrun.
module tb_c157x_rom_fetch;

    localparam int NDR = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            slot_start = 1'b0;
    logic [3:0]      drv_mode = 4'd0;
    logic [29:0]     mem_a = 30'd0;
    logic [15:0]     rom_do;
    logic            mem_req;
    logic [16:0]     mem_addr;
    logic            mem_ack = 1'b0;
    logic [7:0]      mem_q = 8'h00;
    logic            load_wr = 1'b0;
    logic [1:0]      load_sel = 2'd0;
    logic [14:0]     load_addr = 15'd0;
    logic [7:0]      load_data = 8'h00;
    logic [1:0]      empty8k;
    logic            overrun;

    int n_chk = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int ack_dly = 0;
    int c0 = 0;
    logic [16:0] exp_q[$];

    c157x_rom_fetch #(.NDR(NDR), .CACHE(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .slot_start (slot_start),
        .drv_mode   (drv_mode),
        .mem_a      (mem_a),
        .rom_do     (rom_do),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_q      (mem_q),
        .load_wr    (load_wr),
        .load_sel   (load_sel),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .empty8k    (empty8k),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mdata(input logic [16:0] a);
        return a[7:0] ^ {a[16:15], a[14:9]} ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot();
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input logic [14:0] a, input logic [7:0] d);
        load_sel  = sel;
        load_addr = a;
        load_data = d;
        load_wr   = 1'b1;
        tick();
        load_wr   = 1'b0;
    endtask

    task automatic wait_req_done(input string tag);
        int n = 0;
        while (!mem_req && n < 60) begin tick(); n++; end
        while (mem_req && n < 60) begin tick(); n++; end
        chk({tag, "_timeout"}, 32'(n < 60), 32'd1);
    endtask

    // ROM memory model: acks ack_dly cycles after a request appears, checks address stability.
    logic        busy = 1'b0;
    logic        ack_prev = 1'b0;
    logic [16:0] held = 17'd0;
    int          cnt = 0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (reset_n && mem_req) begin
            if (!busy) begin
                busy = 1'b1;
                held = mem_addr;
                cnt  = 0;
            end else begin
                chk("req_stable", 32'(mem_addr), 32'(held));
            end
            if (!ack_prev) begin
                if (cnt >= ack_dly) begin
                    mem_ack = 1'b1;
                    mem_q   = mdata(mem_addr);
                    req_cnt++;
                    chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) chk("req_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
                end else begin
                    cnt++;
                end
            end
        end else begin
            busy = 1'b0;
        end
        ack_prev = mem_ack;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drv_mode = {2'd2, 2'd0};
        mem_a    = {15'h7FFF, 15'h0100};
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_rom_do", 32'(rom_do), 32'hFFFF);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_empty8k", 32'(empty8k), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: two fetches, exact latency
        exp_q.push_back(17'h00100);
        exp_q.push_back(17'h17FFF);
        slot();
        tick(); tick();
        chk("t1_req0", 32'(mem_req), 32'd1);
        chk("t1_addr0", 32'(mem_addr), 32'h00100);
        tick();
        chk("t1_rom0", 32'(rom_do[7:0]), 32'(mdata(17'h00100)));
        chk("t1_rom1_old", 32'(rom_do[15:8]), 32'hFF);
        tick(); tick();
        chk("t1_rom1", 32'(rom_do[15:8]), 32'(mdata(17'h17FFF)));
        chk("t1_overrun", 32'(overrun), 32'd0);
        chk("t1_empty8k", 32'(empty8k), 32'd0);

        // 2: cache hit, then mode change on drive 1
        repeat (4) tick();
        c0 = req_cnt;
        slot();
        repeat (10) tick();
        chk("t2_no_req", 32'(req_cnt - c0), 32'd0);
        chk("t2_rom_hold", 32'(rom_do), 32'({mdata(17'h17FFF), mdata(17'h00100)}));
        drv_mode = {2'd3, 2'd0};
        exp_q.push_back(17'h1FFFF);
        c0 = req_cnt;
        slot();
        repeat (10) tick();
        chk("t2_one_req", 32'(req_cnt - c0), 32'd1);
        chk("t2_rom1", 32'(rom_do[15:8]), 32'(mdata(17'h1FFFF)));

        // 3: slow memory, slot during WAIT
        ack_dly = 12;
        mem_a = {15'h7FFF, 15'h0123};
        exp_q.push_back(17'h00123);
        exp_q.push_back(17'h00123);
        c0 = req_cnt;
        slot();
        repeat (5) tick();
        chk("t3_req_held", 32'(mem_req), 32'd1);
        slot();
        chk("t3_overrun", 32'(overrun), 32'd1);
        wait_req_done("t3_first");
        tick();
        chk("t3_discard", 32'(rom_do[7:0]), 32'(mdata(17'h00100)));
        wait_req_done("t3_refetch");
        tick();
        chk("t3_rom0", 32'(rom_do[7:0]), 32'(mdata(17'h00123)));
        chk("t3_req_cnt", 32'(req_cnt - c0), 32'd2);
        chk("t3_rom1", 32'(rom_do[15:8]), 32'(mdata(17'h1FFFF)));
        ack_dly = 0;

        // 4: empty8k tracking on image 1
        drv_mode = {2'd3, 2'd1};
        tick();
        chk("t4_init", 32'(empty8k), 32'd0);
        load(2'd1, 15'h0000, 8'h12);
        chk("t4_set", 32'(empty8k), 32'd1);
        load(2'd1, 15'h0200, 8'h55);
        chk("t4_clear", 32'(empty8k), 32'd0);
        load(2'd1, 15'h0000, 8'h00);
        chk("t4_reset", 32'(empty8k), 32'd1);
        load(2'd1, 15'h0200, 8'hFF);
        chk("t4_ff_keep", 32'(empty8k), 32'd1);
        load(2'd1, 15'h2200, 8'h55);
        chk("t4_hi_keep", 32'(empty8k), 32'd1);
        load(2'd1, 15'h0080, 8'h55);
        chk("t4_pg0_keep", 32'(empty8k), 32'd1);
        load(2'd2, 15'h0000, 8'h00);
        chk("t4_other_img", 32'(empty8k), 32'd1);
        drv_mode = {2'd3, 2'd2};
        tick();
        chk("t4_mode_sel", 32'(empty8k), 32'd1);
        drv_mode = {2'd3, 2'd0};
        tick();
        chk("t4_mode0", 32'(empty8k), 32'd0);

        // 5: load to image 0 invalidates cached drive 0
        c0 = req_cnt;
        slot();
        repeat (10) tick();
        chk("t5_cached", 32'(req_cnt - c0), 32'd0);
        load(2'd0, 15'h0400, 8'h00);
        exp_q.push_back(17'h00123);
        slot();
        repeat (10) tick();
        chk("t5_refetch", 32'(req_cnt - c0), 32'd1);
        chk("t5_rom0", 32'(rom_do[7:0]), 32'(mdata(17'h00123)));

        // 6: async reset during WAIT
        ack_dly = 12;
        mem_a = {15'h7FFF, 15'h0055};
        exp_q.push_back(17'h00055);
        slot();
        repeat (6) tick();
        chk("t6_in_wait", 32'(mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_rom", 32'(rom_do), 32'hFFFF);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        chk("t6_rst_e8k", 32'(empty8k), 32'd0);
        exp_q.delete();
        ack_dly = 0;
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.push_back(17'h00055);
        exp_q.push_back(17'h1FFFF);
        c0 = req_cnt;
        slot();
        repeat (10) tick();
        chk("t6_req_cnt", 32'(req_cnt - c0), 32'd2);
        chk("t6_rom", 32'(rom_do), 32'({mdata(17'h1FFFF), mdata(17'h00055)}));
        chk("t6_overrun", 32'(overrun), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
